// File: rtl/sram_write_buffer.sv
// sram_write_buffer
//   Posted-store FIFO between the memory stage and the SRAM controller.
//   Stores are accepted in a single cycle and drained one at a time to the
//   SRAM controller, which may take several cycles per write. Pending store
//   data is forwarded to memory-stage reads, and cache-miss reads
//   (rd_pending) take priority over starting a new drain.
//
// Ports
//   CLK             in   clock, all state on rising edge
//   RST             in   asynchronous reset, active-low
//   wr_valid        in   store request from memory stage
//   wr_addr         in   store byte address (AW bits)
//   wr_data         in   store data (32 bits)
//   wr_ready        out  store accepted when wr_valid && wr_ready
//   fwd_addr        in   read address probed for forwarding
//   fwd_hit         out  a queued store matches fwd_addr word address
//   fwd_data        out  data of the newest matching queued store, else 0
//   rd_pending      in   cache controller wants the SRAM port for a read
//   sram_writeEn    out  write request to SRAM controller
//   sram_address    out  write address (head entry)
//   sram_writeData  out  write data (head entry)
//   SRAM_ready      in   one-cycle pulse: SRAM controller finished access
//   empty           out  no queued stores
//   full            out  buffer holds DEPTH stores
//
// FSM states
//   state | meaning
//   IDLE  | no write outstanding; start one when non-empty and no read pending
//   WRITE | sram_writeEn high for head entry; wait for SRAM_ready, then pop
module sram_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    output logic          wr_ready,
    input  logic [AW-1:0] fwd_addr,
    output logic          fwd_hit,
    output logic [31:0]   fwd_data,
    input  logic          rd_pending,
    output logic          sram_writeEn,
    output logic [AW-1:0] sram_address,
    output logic [31:0]   sram_writeData,
    input  logic          SRAM_ready,
    output logic          empty,
    output logic          full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [AW-1:0]   mem_addr [DEPTH];
    logic [31:0]     mem_data [DEPTH];

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic            push;
    logic            pop;
    logic [PW-1:0]   fwd_idx;

    // Byte-lane bits never take part in the forwarding compare.
    logic            unused_fwd_lsb;
    assign unused_fwd_lsb = ^fwd_addr[1:0];

    // Flags come from the registered count only, so a pop in the same cycle
    // never opens a slot for a push.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign wr_ready = !full;
    assign push     = wr_valid && !full;

    // Head entry is always presented; it cannot change during WRITE because
    // head only moves on pop and tail never lands on head while non-empty.
    assign sram_address   = mem_addr[head];
    assign sram_writeData = mem_data[head];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        sram_writeEn = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !rd_pending) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                sram_writeEn = 1'b1;
                if (SRAM_ready) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry contents are deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_addr[tail] <= wr_addr;
            mem_data[tail] <= wr_data;
        end
    end

    // Walk from oldest to youngest valid entry; a later match overrides an
    // earlier one, so the youngest matching store wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head + PW'(k);
            if ((CW'(k) < count) &&
                (mem_addr[fwd_idx][AW-1:2] == fwd_addr[AW-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data[fwd_idx];
            end
        end
    end

endmodule

// File: tb/tb_sram_write_buffer.sv
module tb_sram_write_buffer;

    logic        CLK;
    logic        RST;
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [31:0] fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        rd_pending;
    logic        sram_writeEn;
    logic [31:0] sram_address;
    logic [31:0] sram_writeData;
    logic        SRAM_ready;
    logic        empty;
    logic        full;

    int nvec;
    int nerr;

    sram_write_buffer #(.DEPTH(4), .AW(32)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .fwd_addr       (fwd_addr),
        .fwd_hit        (fwd_hit),
        .fwd_data       (fwd_data),
        .rd_pending     (rd_pending),
        .sram_writeEn   (sram_writeEn),
        .sram_address   (sram_address),
        .sram_writeData (sram_writeData),
        .SRAM_ready     (SRAM_ready),
        .empty          (empty),
        .full           (full)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wv;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] fa;
        logic        rp;
        logic        sr;
        logic        e_wrdy;
        logic        e_hit;
        logic [31:0] e_fd;
        logic        e_wen;
        logic [31:0] e_sa;
        logic [31:0] e_sd;
        logic        e_empty;
        logic        e_full;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic wv, logic [31:0] wa, logic [31:0] wd,
                                logic [31:0] fa, logic rp, logic sr,
                                logic e_wrdy, logic e_hit, logic [31:0] e_fd,
                                logic e_wen, logic [31:0] e_sa, logic [31:0] e_sd,
                                logic e_empty, logic e_full);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.fa = fa; v.rp = rp; v.sr = sr;
        v.e_wrdy = e_wrdy; v.e_hit = e_hit; v.e_fd = e_fd; v.e_wen = e_wen;
        v.e_sa = e_sa; v.e_sd = e_sd; v.e_empty = e_empty; v.e_full = e_full;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge CLK);
        wr_valid   = v.wv;
        wr_addr    = v.wa;
        wr_data    = v.wd;
        fwd_addr   = v.fa;
        rd_pending = v.rp;
        SRAM_ready = v.sr;
        #1;
        check($sformatf("v%0d wr_ready", idx), {31'd0, wr_ready}, {31'd0, v.e_wrdy});
        check($sformatf("v%0d fwd_hit", idx), {31'd0, fwd_hit}, {31'd0, v.e_hit});
        check($sformatf("v%0d fwd_data", idx), fwd_data, v.e_fd);
        check($sformatf("v%0d sram_writeEn", idx), {31'd0, sram_writeEn}, {31'd0, v.e_wen});
        check($sformatf("v%0d empty", idx), {31'd0, empty}, {31'd0, v.e_empty});
        check($sformatf("v%0d full", idx), {31'd0, full}, {31'd0, v.e_full});
        if (v.e_wen) begin
            check($sformatf("v%0d sram_address", idx), sram_address, v.e_sa);
            check($sformatf("v%0d sram_writeData", idx), sram_writeData, v.e_sd);
        end
    endtask

    task automatic idle_inputs();
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_pending = 1'b0;
        SRAM_ready = 1'b0;
    endtask

    initial begin
        int   waited;
        int   sent;
        int   recv;
        int   same;
        int   cnt;
        int   cyc;
        logic prev_wen;
        logic acc;
        logic pp;

        nvec = 0;
        nerr = 0;
        RST  = 1'b0;
        fwd_addr = 32'h400;
        idle_inputs();

        // wv  wa        wd            fa      rp sr | wrdy hit fd            wen sa      sd            emp full
        tbl.push_back(mk(1, 32'h400, 32'hDEADBEEF, 32'h400, 0, 0, 1, 0, 32'h0,        0, 32'h0,   32'h0,        1, 0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h400, 0, 0, 1, 1, 32'hDEADBEEF, 0, 32'h0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h400, 0, 0, 1, 1, 32'hDEADBEEF, 1, 32'h400, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h400, 0, 1, 1, 1, 32'hDEADBEEF, 1, 32'h400, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h400, 0, 0, 1, 0, 32'h0,        0, 32'h0,   32'h0,        1, 0));
        tbl.push_back(mk(1, 32'h10,  32'h1,        32'h10,  1, 0, 1, 0, 32'h0,        0, 32'h0,   32'h0,        1, 0));
        tbl.push_back(mk(1, 32'h20,  32'h2,        32'h10,  1, 0, 1, 1, 32'h1,        0, 32'h0,   32'h0,        0, 0));
        tbl.push_back(mk(1, 32'h12,  32'h3,        32'h10,  1, 0, 1, 1, 32'h1,        0, 32'h0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h10,  1, 0, 1, 1, 32'h3,        0, 32'h0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h30,  1, 0, 1, 0, 32'h0,        0, 32'h0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h20,  1, 0, 1, 1, 32'h2,        0, 32'h0,   32'h0,        0, 0));
        tbl.push_back(mk(1, 32'h40,  32'h4,        32'h40,  1, 0, 1, 0, 32'h0,        0, 32'h0,   32'h0,        0, 0));
        tbl.push_back(mk(1, 32'h50,  32'h5,        32'h50,  1, 0, 0, 0, 32'h0,        0, 32'h0,   32'h0,        0, 1));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h50,  1, 0, 0, 0, 32'h0,        0, 32'h0,   32'h0,        0, 1));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h40,  0, 0, 0, 1, 32'h4,        0, 32'h0,   32'h0,        0, 1));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h10,  1, 0, 0, 1, 32'h3,        1, 32'h10,  32'h1,        0, 1));
        tbl.push_back(mk(1, 32'h60,  32'h6,        32'h10,  1, 1, 0, 1, 32'h3,        1, 32'h10,  32'h1,        0, 1));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h60,  0, 0, 1, 0, 32'h0,        0, 32'h0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h20,  0, 1, 1, 1, 32'h2,        1, 32'h20,  32'h2,        0, 0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h10,  0, 0, 1, 1, 32'h3,        0, 32'h0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h10,  0, 1, 1, 1, 32'h3,        1, 32'h12,  32'h3,        0, 0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h10,  0, 0, 1, 0, 32'h0,        0, 32'h0,   32'h0,        0, 0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h40,  0, 1, 1, 1, 32'h4,        1, 32'h40,  32'h4,        0, 0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h40,  0, 1, 1, 0, 32'h0,        0, 32'h0,   32'h0,        1, 0));
        tbl.push_back(mk(0, 32'h0,   32'h0,        32'h40,  0, 0, 1, 0, 32'h0,        0, 32'h0,   32'h0,        1, 0));

        // Reset state while RST is held low.
        repeat (2) @(negedge CLK);
        #1;
        check("rst empty", {31'd0, empty}, 32'd1);
        check("rst full", {31'd0, full}, 32'd0);
        check("rst wr_ready", {31'd0, wr_ready}, 32'd1);
        check("rst sram_writeEn", {31'd0, sram_writeEn}, 32'd0);
        check("rst fwd_hit", {31'd0, fwd_hit}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end
        @(negedge CLK);
        idle_inputs();

        // Reset asserted while a write is in flight.
        @(negedge CLK);
        wr_valid = 1'b1;
        wr_addr  = 32'h800;
        wr_data  = 32'h12345678;
        fwd_addr = 32'h800;
        @(negedge CLK);
        wr_valid = 1'b0;
        waited = 0;
        while (!sram_writeEn && waited < 10) begin
            @(negedge CLK);
            waited++;
        end
        check("midwr writeEn up", {31'd0, sram_writeEn}, 32'd1);
        RST = 1'b0;
        #1;
        check("midwr writeEn", {31'd0, sram_writeEn}, 32'd0);
        check("midwr empty", {31'd0, empty}, 32'd1);
        check("midwr wr_ready", {31'd0, wr_ready}, 32'd1);
        check("midwr fwd_hit", {31'd0, fwd_hit}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        #1;
        check("postrst empty", {31'd0, empty}, 32'd1);
        check("postrst writeEn", {31'd0, sram_writeEn}, 32'd0);

        // Ten stores streamed through, exercising pointer wrap and
        // simultaneous push/pop.
        sent = 0; recv = 0; same = 0; cnt = 0; cyc = 0;
        prev_wen = 1'b0;
        while (recv < 10 && cyc < 300) begin
            @(negedge CLK);
            wr_valid   = (sent < 10);
            wr_addr    = 32'h1000 + 32'(sent) * 32'd4;
            wr_data    = 32'hA500_0000 + 32'(sent) * 32'h111;
            rd_pending = 1'b0;
            SRAM_ready = sram_writeEn && prev_wen;
            #1;
            check("wrap empty", {31'd0, empty}, {31'd0, (cnt == 0)});
            check("wrap full", {31'd0, full}, {31'd0, (cnt == 4)});
            acc = wr_valid && wr_ready;
            pp  = sram_writeEn && SRAM_ready;
            if (pp) begin
                check($sformatf("wrap addr %0d", recv), sram_address, 32'h1000 + 32'(recv) * 32'd4);
                check($sformatf("wrap data %0d", recv), sram_writeData, 32'hA500_0000 + 32'(recv) * 32'h111);
                recv++;
            end
            if (acc && pp) same++;
            if (acc) sent++;
            cnt = cnt + (acc ? 1 : 0) - (pp ? 1 : 0);
            prev_wen = sram_writeEn && !SRAM_ready;
            cyc++;
        end
        check("wrap drained", 32'(recv), 32'd10);
        check("wrap count bound", {31'd0, (cnt >= 0 && cnt <= 4)}, 32'd1);
        check("wrap push+pop seen", {31'd0, (same > 0)}, 32'd1);
        @(negedge CLK);
        idle_inputs();
        #1;
        check("wrap final empty", {31'd0, empty}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
